// File: rtl/ps_pwm_pkg.sv
// Shared types and default sizing for the phase-shifted PWM dead-time block.
package ps_pwm_pkg;

    localparam int N_LEGS_DEF = 4;
    localparam int DT_W_DEF   = 4;

    typedef enum logic [2:0] {
        ST_SAFE    = 3'd0,
        ST_LOW     = 3'd1,
        ST_DT_RISE = 3'd2,
        ST_HIGH    = 3'd3,
        ST_DT_FALL = 3'd4
    } leg_state_t;

endpackage

// File: rtl/deadtime_leg.sv
// One half-bridge leg: dead-time FSM with a down-counter and registered gate decode.
module deadtime_leg
    import ps_pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            force_safe,
    input  logic            pwm,
    input  logic [DT_W-1:0] dt_m1,
    output logic            gate_hi,
    output logic            gate_lo
);

    // state      | meaning
    // ST_SAFE    | both gates off, held by kill / ena low / reset
    // ST_LOW     | low-side gate on
    // ST_DT_RISE | both off, counting down before the high side turns on
    // ST_HIGH    | high-side gate on
    // ST_DT_FALL | both off, counting down before the low side turns on

    leg_state_t      state, state_nx;
    logic [DT_W-1:0] cnt, cnt_nx;
    logic            from_safe, from_safe_nx;

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        from_safe_nx = from_safe;
        if (force_safe) begin
            state_nx     = ST_SAFE;
            cnt_nx       = '0;
            from_safe_nx = 1'b0;
        end else begin
            case (state)
                ST_SAFE: begin
                    state_nx     = ST_DT_FALL;
                    cnt_nx       = dt_m1;
                    from_safe_nx = 1'b1;
                end
                ST_LOW: begin
                    if (pwm) begin
                        state_nx = ST_DT_RISE;
                        cnt_nx   = dt_m1;
                    end
                end
                ST_DT_RISE: begin
                    if (!pwm) begin
                        state_nx = ST_LOW;
                        cnt_nx   = '0;
                    end else if (cnt == '0) begin
                        state_nx = ST_HIGH;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (!pwm) begin
                        state_nx     = ST_DT_FALL;
                        cnt_nx       = dt_m1;
                        from_safe_nx = 1'b0;
                    end
                end
                ST_DT_FALL: begin
                    // A recovery from SAFE always lands in LOW; pwm cannot abort it.
                    if (pwm && !from_safe) begin
                        state_nx = ST_HIGH;
                        cnt_nx   = '0;
                    end else if (cnt == '0) begin
                        state_nx     = ST_LOW;
                        from_safe_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                default: begin
                    state_nx = ST_SAFE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SAFE;
            cnt       <= '0;
            from_safe <= 1'b0;
            gate_hi   <= 1'b0;
            gate_lo   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            from_safe <= from_safe_nx;
            gate_hi   <= (state_nx == ST_HIGH);
            gate_lo   <= (state_nx == ST_LOW);
        end
    end

endmodule

// File: rtl/ps_pwm_deadtime.sv
// Dead-time insertion for N phase-shifted PWM legs, with shared dead-time register and kill latch.
module ps_pwm_deadtime
    import ps_pwm_pkg::*;
#(
    parameter int N_LEGS = N_LEGS_DEF,
    parameter int DT_W   = DT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [N_LEGS-1:0] pwm_in,
    input  logic [DT_W-1:0]   dt_cfg,
    input  logic              dt_load,
    input  logic              kill,
    output logic [N_LEGS-1:0] gate_hi,
    output logic [N_LEGS-1:0] gate_lo,
    output logic              fault
);

    logic [DT_W-1:0] dt_reg;
    logic [DT_W-1:0] dt_m1;
    logic            force_safe;

    always_ff @(posedge clk) begin
        if (rst) begin
            dt_reg <= DT_W'(1);
            fault  <= 1'b0;
        end else begin
            if (dt_load) dt_reg <= dt_cfg;
            if (kill)    fault  <= 1'b1;
        end
    end

    // A zero dead time is stretched to one cycle so the gates never swap in a single edge.
    assign dt_m1      = (dt_reg == '0) ? '0 : dt_reg - DT_W'(1);
    assign force_safe = kill | ~ena;

    for (genvar i = 0; i < N_LEGS; i++) begin : g_leg
        deadtime_leg #(.DT_W(DT_W)) u_leg (
            .clk        (clk),
            .rst        (rst),
            .force_safe (force_safe),
            .pwm        (pwm_in[i]),
            .dt_m1      (dt_m1),
            .gate_hi    (gate_hi[i]),
            .gate_lo    (gate_lo[i])
        );
    end

endmodule
